// File: rtl/resv_sched_ctrl.sv
// Dispatch/issue controller for two reservation stations sharing one execution unit; 0-cycle dispatch and issue.
// Backpressure: ready drops on a full target station, STALL or FLUSH. Optional perf counters: RESV_SCHED_PERF_EN.
module resv_sched_ctrl #(
    parameter int CLR_CYCLES = 2,
    parameter int W_PERF     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              DFI_PC_valid,
    input  logic              DFI_PC_pipe,
    input  logic              CFI_PC_full0,
    input  logic              CFI_PC_full1,
    input  logic              CDI_PV_c00,
    input  logic              CDI_PV_c01,
    input  logic              CDI_PV_c10,
    input  logic              CDI_PV_c11,
    input  logic              CFI_PC_eu_ready,
    input  logic              CFI_PC_flush,
    input  logic              CFI_PC_stall,
    output logic              CFO_PC_ready,
    output logic              CFO_PC_ena0,
    output logic              CFO_PC_ena1,
    output logic              CFO_PC_stall0,
    output logic              CFO_PC_stall1,
    output logic              CFO_PC_clear0,
    output logic              CFO_PC_clear1,
    output logic [1:0]        CDO_PC_s1_0,
    output logic [1:0]        CDO_PC_s1_1,
    output logic              CFO_PC_issue,
    output logic              CDO_PC_gnt,
    output logic [W_PERF-1:0] CDO_PD_perf_disp,
    output logic [W_PERF-1:0] CDO_PD_perf_iss,
    output logic [W_PERF-1:0] CDO_PD_perf_blk
);
    typedef enum logic [1:0] {S_FLUSH = 2'd0, S_RUN = 2'd1, S_STALL = 2'd2} state_t;

    localparam logic [3:0] CNT_INIT = 4'(CLR_CYCLES - 1);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_cnt;
    logic       r_rr;
    logic       w_run;
    logic       w_elig0;
    logic       w_elig1;
    logic       w_gnt;
    logic [1:0] w_sel0;
    logic [1:0] w_sel1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FLUSH;
            r_cnt   <= CNT_INIT;
        end else begin
            r_state <= w_next;
            // Reload on entry and on a repeated flush; otherwise count down while clearing.
            if (w_next == S_FLUSH && (r_state != S_FLUSH || CFI_PC_flush))
                r_cnt <= CNT_INIT;
            else if (r_state == S_FLUSH && r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FLUSH: begin
                if (!CFI_PC_flush && r_cnt == 4'd0)
                    w_next = CFI_PC_stall ? S_STALL : S_RUN;
            end
            S_RUN, S_STALL: begin
                if (CFI_PC_flush)      w_next = S_FLUSH;
                else if (CFI_PC_stall) w_next = S_STALL;
                else                   w_next = S_RUN;
            end
            default: w_next = S_FLUSH;
        endcase
    end

    always_comb begin
        w_run   = (r_state == S_RUN) && !rst;
        w_elig0 = CDI_PV_c00 || CDI_PV_c01;
        w_elig1 = CDI_PV_c10 || CDI_PV_c11;
        w_sel0  = CDI_PV_c00 ? 2'b01 : (CDI_PV_c01 ? 2'b10 : 2'b00);
        w_sel1  = CDI_PV_c10 ? 2'b01 : (CDI_PV_c11 ? 2'b10 : 2'b00);
        w_gnt   = (w_elig0 && w_elig1) ? r_rr : w_elig1;

        CFO_PC_clear0 = (r_state == S_FLUSH) || rst;
        CFO_PC_clear1 = CFO_PC_clear0;
        CFO_PC_stall0 = (r_state == S_STALL) && !rst;
        CFO_PC_stall1 = CFO_PC_stall0;
        CFO_PC_ready  = w_run && !(DFI_PC_pipe ? CFI_PC_full1 : CFI_PC_full0);
        CFO_PC_ena0   = DFI_PC_valid && CFO_PC_ready && !DFI_PC_pipe;
        CFO_PC_ena1   = DFI_PC_valid && CFO_PC_ready && DFI_PC_pipe;
        CFO_PC_issue  = w_run && CFI_PC_eu_ready && (w_elig0 || w_elig1);
        CDO_PC_gnt    = CFO_PC_issue && w_gnt;
        CDO_PC_s1_0   = (CFO_PC_issue && !w_gnt) ? w_sel0 : 2'b00;
        CDO_PC_s1_1   = (CFO_PC_issue && w_gnt) ? w_sel1 : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst)               r_rr <= 1'b0;
        else if (CFO_PC_issue) r_rr <= ~CDO_PC_gnt;
    end

`ifdef RESV_SCHED_PERF_EN
    logic [W_PERF-1:0] r_perf_disp;
    logic [W_PERF-1:0] r_perf_iss;
    logic [W_PERF-1:0] r_perf_blk;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_disp <= '0;
            r_perf_iss  <= '0;
            r_perf_blk  <= '0;
        end else begin
            if (CFO_PC_ena0 || CFO_PC_ena1)     r_perf_disp <= r_perf_disp + W_PERF'(1);
            if (CFO_PC_issue)                   r_perf_iss  <= r_perf_iss + W_PERF'(1);
            if (DFI_PC_valid && !CFO_PC_ready)  r_perf_blk  <= r_perf_blk + W_PERF'(1);
        end
    end

    assign CDO_PD_perf_disp = r_perf_disp;
    assign CDO_PD_perf_iss  = r_perf_iss;
    assign CDO_PD_perf_blk  = r_perf_blk;
`else
    assign CDO_PD_perf_disp = '0;
    assign CDO_PD_perf_iss  = '0;
    assign CDO_PD_perf_blk  = '0;
`endif

endmodule

// File: tb/tb_resv_sched_ctrl.sv
// Randomized scoreboard bench for resv_sched_ctrl against a cycle-level behavioural model.
module tb_resv_sched_ctrl;
    localparam int CLR = 2;

    typedef struct packed {
        logic rst, valid, pipe, f0, f1, c00, c01, c10, c11, eu, fl, st;
    } stim_t;

    typedef struct {
        logic ready, ena0, ena1, stall0, stall1, clear0, clear1;
        logic [1:0] s0, s1;
        logic issue, gnt;
        logic [15:0] pd, pi, pb;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid = 0, pipe = 0, f0 = 0, f1 = 0, c00 = 0, c01 = 0, c10 = 0, c11 = 0;
    logic eu = 0, fl = 0, st = 0;
    logic ready, ena0, ena1, stall0, stall1, clear0, clear1, issue, gnt;
    logic [1:0] s1_0, s1_1;
    logic [15:0] perf_disp, perf_iss, perf_blk;

    always #5 clk = ~clk;

    resv_sched_ctrl #(.CLR_CYCLES(CLR), .W_PERF(16)) dut (
        .clk(clk), .rst(rst),
        .DFI_PC_valid(valid), .DFI_PC_pipe(pipe),
        .CFI_PC_full0(f0), .CFI_PC_full1(f1),
        .CDI_PV_c00(c00), .CDI_PV_c01(c01), .CDI_PV_c10(c10), .CDI_PV_c11(c11),
        .CFI_PC_eu_ready(eu), .CFI_PC_flush(fl), .CFI_PC_stall(st),
        .CFO_PC_ready(ready), .CFO_PC_ena0(ena0), .CFO_PC_ena1(ena1),
        .CFO_PC_stall0(stall0), .CFO_PC_stall1(stall1),
        .CFO_PC_clear0(clear0), .CFO_PC_clear1(clear1),
        .CDO_PC_s1_0(s1_0), .CDO_PC_s1_1(s1_1),
        .CFO_PC_issue(issue), .CDO_PC_gnt(gnt),
        .CDO_PD_perf_disp(perf_disp), .CDO_PD_perf_iss(perf_iss), .CDO_PD_perf_blk(perf_blk)
    );

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    // Behavioural model: mode 0 = clearing, 1 = running, 2 = stalled.
    int          m_mode = 0;
    int          m_clear_left = CLR;
    int          m_last_gnt = 1;
    logic [15:0] m_pd = 0, m_pi = 0, m_pb = 0;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        bit in_run, el0, el1;
        int  w;
        rst = s.rst; valid = s.valid; pipe = s.pipe; f0 = s.f0; f1 = s.f1;
        c00 = s.c00; c01 = s.c01; c10 = s.c10; c11 = s.c11;
        eu = s.eu; fl = s.fl; st = s.st;

        in_run   = !s.rst && m_mode == 1;
        e.clear0 = s.rst || m_mode == 0;
        e.clear1 = e.clear0;
        e.stall0 = !s.rst && m_mode == 2;
        e.stall1 = e.stall0;
        e.ready  = in_run && !(s.pipe ? s.f1 : s.f0);
        e.ena0   = s.valid && e.ready && !s.pipe;
        e.ena1   = s.valid && e.ready && s.pipe;
        el0 = s.c00 || s.c01;
        el1 = s.c10 || s.c11;
        e.issue = in_run && s.eu && (el0 || el1);
        e.s0 = 2'b00; e.s1 = 2'b00; e.gnt = 1'b0;
        if (e.issue) begin
            if (el0 && el1) w = 1 - m_last_gnt;
            else            w = el0 ? 0 : 1;
            e.gnt = (w == 1);
            if (w == 0) e.s0 = s.c00 ? 2'b01 : 2'b10;
            else        e.s1 = s.c10 ? 2'b01 : 2'b10;
        end
`ifdef RESV_SCHED_PERF_EN
        e.pd = m_pd; e.pi = m_pi; e.pb = m_pb;
`else
        e.pd = 0; e.pi = 0; e.pb = 0;
`endif
        exp_q.push_back(e);

        @(posedge clk);
        if (s.rst) begin
            m_mode = 0; m_clear_left = CLR; m_last_gnt = 1;
            m_pd = 0; m_pi = 0; m_pb = 0;
        end else begin
            if (e.ena0 || e.ena1)      m_pd = m_pd + 1;
            if (e.issue)               m_pi = m_pi + 1;
            if (s.valid && !e.ready)   m_pb = m_pb + 1;
            if (e.issue)               m_last_gnt = e.gnt ? 1 : 0;
            if (m_mode == 0) begin
                if (s.fl) m_clear_left = CLR;
                else begin
                    m_clear_left--;
                    if (m_clear_left == 0) m_mode = s.st ? 2 : 1;
                end
            end else if (s.fl) begin
                m_mode = 0; m_clear_left = CLR;
            end else m_mode = s.st ? 2 : 1;
        end
        #1;
    endtask

    function automatic stim_t mk(input logic r, input logic v, input logic p, input logic ff0,
                                 input logic ff1, input logic [3:0] c, input logic e,
                                 input logic f, input logic s);
        stim_t x;
        x = {r, v, p, ff0, ff1, c[0], c[1], c[2], c[3], e, f, s};
        return x;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ready", ready, e.ready);
                chk("ena0", ena0, e.ena0);
                chk("ena1", ena1, e.ena1);
                chk("stall0", stall0, e.stall0);
                chk("stall1", stall1, e.stall1);
                chk("clear0", clear0, e.clear0);
                chk("clear1", clear1, e.clear1);
                chk("issue", issue, e.issue);
                chk("s1_0", s1_0, e.s0);
                chk("s1_1", s1_1, e.s1);
                if (e.issue) chk("gnt", gnt, e.gnt);
                chk("perf_disp", perf_disp, e.pd);
                chk("perf_iss", perf_iss, e.pi);
                chk("perf_blk", perf_blk, e.pb);
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        int    wait_cyc;
        repeat (2) @(posedge clk);
        #1;
        // Reset then two clearing cycles, then first run cycle dispatches to station 0.
        step(mk(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
        step(mk(0, 1, 0, 0, 0, 4'b0000, 0, 0, 0));
        step(mk(0, 1, 0, 0, 0, 4'b0000, 0, 0, 0));
        step(mk(0, 1, 0, 0, 0, 4'b0000, 0, 0, 0));
        // Both stations' cand0 ready: round-robin alternation.
        repeat (4) step(mk(0, 0, 0, 0, 0, 4'b0101, 1, 0, 0));
        // Only station 1 cand1 ready, with and without eu_ready.
        step(mk(0, 0, 0, 0, 0, 4'b1000, 1, 0, 0));
        step(mk(0, 0, 0, 0, 0, 4'b1000, 0, 0, 0));
        step(mk(0, 0, 0, 0, 0, 4'b0101, 1, 0, 0));
        // Blocked dispatch to a full station 1.
        step(mk(0, 1, 1, 0, 1, 4'b0000, 0, 0, 0));
        // Stall, flush pulse mid-stall, stall held through clearing, then release.
        step(mk(0, 1, 0, 0, 0, 4'b0101, 1, 0, 1));
        step(mk(0, 1, 0, 0, 0, 4'b0101, 1, 1, 1));
        step(mk(0, 1, 0, 0, 0, 4'b0101, 1, 0, 1));
        step(mk(0, 1, 0, 0, 0, 4'b0101, 1, 0, 1));
        step(mk(0, 1, 0, 0, 0, 4'b0101, 1, 0, 1));
        step(mk(0, 1, 0, 0, 0, 4'b0101, 1, 0, 0));
        step(mk(0, 1, 0, 0, 0, 4'b0101, 1, 0, 0));
        // Ten back-to-back dispatches after a fresh reset.
        step(mk(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
        repeat (2) step(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
        for (int i = 0; i < 10; i++) step(mk(0, 1, i[0], 0, 0, 4'b0000, 0, 0, 0));
        step(mk(0, 0, 0, 0, 0, 4'b0000, 0, 0, 0));
        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            s       = stim_t'($urandom);
            s.rst   = ($urandom_range(0, 149) == 0);
            s.fl    = ($urandom_range(0, 24) == 0);
            s.st    = ($urandom_range(0, 7) == 0);
            s.eu    = ($urandom_range(0, 3) != 0);
            s.f0    = ($urandom_range(0, 3) == 0);
            s.f1    = ($urandom_range(0, 3) == 0);
            step(s);
        end
        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/resv_sched_ctrl.md
RESV_SCHED_CTRL -- requirements
Module: resv_sched_ctrl

Interface
REQ-001 Parameter CLR_CYCLES, default 2: number of cycles clear is held on a flush (legal range 1..15).
REQ-002 Parameter W_PERF, default 16: width of each performance counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 DFI_PC_valid  input  1  decode offers one instruction this cycle.
REQ-006 DFI_PC_pipe  input  1  target station of the offered instruction (0 = station 0, 1 = station 1).
REQ-007 CFI_PC_full0 / CFI_PC_full1  input  1 each  full flag of station 0 / 1.
REQ-008 CDI_PV_c00, CDI_PV_c01 / CDI_PV_c10, CDI_PV_c11  input  1 each  candidate-0 / candidate-1 ready, for station 0 / station 1.
REQ-009 CFI_PC_eu_ready  input  1  shared execution unit accepts an issue this cycle.
REQ-010 CFI_PC_flush  input  1  flush request (mispredict).
REQ-011 CFI_PC_stall  input  1  downstream stall request.
REQ-012 CFO_PC_ready  output  1  dispatch accepted this cycle.
REQ-013 CFO_PC_ena0 / CFO_PC_ena1  output  1 each  insert enable to station 0 / 1.
REQ-014 CFO_PC_stall0 / CFO_PC_stall1  output  1 each  stall to station 0 / 1.
REQ-015 CFO_PC_clear0 / CFO_PC_clear1  output  1 each  clear to station 0 / 1.
REQ-016 CDO_PC_s1_0 / CDO_PC_s1_1  output  2 each  candidate select to station 0 / 1 (bit0 = cand0, bit1 = cand1, one-hot or zero).
REQ-017 CFO_PC_issue  output  1  one issue granted to the execution unit this cycle.
REQ-018 CDO_PC_gnt  output  1  index of the granted station; valid only when CFO_PC_issue = 1.
REQ-019 CDO_PD_perf_disp, CDO_PD_perf_iss, CDO_PD_perf_blk  output  W_PERF each  performance counters.

Function
REQ-020 FSM states: FLUSH, RUN, STALL. Transition priority: rst > CFI_PC_flush > CFI_PC_stall.
REQ-021 FLUSH behaviour:
- clear0 = clear1 = 1, ready = 0, ena = 0, s1 = 0, issue = 0.
- A down-counter loads CLR_CYCLES-1 on entry.
- FLUSH exits when the counter reaches 0 and flush = 0; exit goes to STALL if stall = 1, else RUN.
- flush asserted while already in FLUSH reloads the counter.
REQ-022 RUN: on flush go to FLUSH; else on stall go to STALL; else stay in RUN.
REQ-023 STALL behaviour:
- stall0 = stall1 = 1, ready = 0, ena = 0, s1 = 0, issue = 0.
- Returns to RUN in the cycle after stall deasserts; flush takes it to FLUSH.
REQ-024 Dispatch is combinational and valid only in RUN:
- ready = (state == RUN) and not full[pipe].
- ena_k = valid and ready and (pipe == k).
- At most one of ena0/ena1 is asserted in any cycle.
REQ-025 A station is eligible when it has either candidate ready; its select prefers cand0 (01) over cand1 (10).
REQ-026 Issue arbitration, in RUN with eu_ready = 1 and at least one station eligible:
- Grant one station; issue = 1.
- Drive s1 for the granted station only; the other station's s1 = 00.
REQ-027 Round-robin pointer rr, 1 bit:
- When both stations are eligible, grant station rr.
- After any grant, rr <= gnt XOR 1.
- rr is unchanged when no grant occurs.
REQ-028 eu_ready = 0 gives issue = 0, both s1 = 00 and rr unchanged.
REQ-029 Dispatch and issue to the same station in the same cycle are both permitted; the station resolves its own count.
REQ-030 All outputs except the FSM, counter and rr registers are combinational from the current state and inputs; dispatch and issue latency is 0 cycles.

Reset
REQ-031 rst = 1 at a clock edge sets:
- state = FLUSH, flush counter = CLR_CYCLES-1, rr = 0;
- all perf counters = 0.
REQ-032 Output values during and after reset:
- While rst is high, outputs follow FLUSH: clear0/1 = 1 and every other 1-bit output = 0.
- The first RUN cycle is CLR_CYCLES cycles after rst deasserts.
REQ-033 rst asserted mid-flush or mid-stall overrides everything and restarts the FLUSH sequence.

Configuration
REQ-034 Macro RESV_SCHED_PERF_EN.
- Defined: perf_disp counts cycles with ena0 or ena1 = 1, perf_iss counts issue = 1, perf_blk counts cycles with valid = 1 and ready = 0.
- All three counters wrap modulo 2^W_PERF and are cleared only by rst.
- Not defined: no counter registers exist and the three perf outputs are constant 0.

Verification
REQ-035 rst high 1 cycle, then low, no flush or stall -> clear0/1 = 1 for 2 cycles, ready = 0; third cycle RUN, ready = 1 with valid = 1, pipe = 0, full0 = 0.
REQ-036 RUN, valid = 1, pipe = 1, full1 = 1, full0 = 0 -> ready = 0, ena0 = ena1 = 0, perf_blk increments (macro on).
REQ-037 RUN, eu_ready = 1, c00 = c10 = 1 held 4 cycles from rr = 0 -> gnt = 0,1,0,1; s1_0 = 01 on even cycles, s1_1 = 01 on odd cycles, the other 00.
REQ-038 RUN, only c11 = 1, eu_ready = 1 -> issue = 1, gnt = 1, s1_1 = 10, rr becomes 0; same with eu_ready = 0 -> issue = 0, s1 = 00, rr unchanged.
REQ-039 Stall and flush sequence -> STALL, ena and issue suppressed, clear held 2 cycles, then STALL:
- RUN, stall = 1 for 3 cycles -> stall0/1 = 1, ena and issue suppressed.
- Flush pulsed in the 2nd stall cycle -> FLUSH, clear held 2 cycles, then STALL because stall is still 1.
- Stall low -> RUN the next cycle.
REQ-040 Macro undefined, 10 dispatches -> all perf outputs read 0; macro defined, perf_disp = 10 and perf_disp wraps to 0 after 2^16 dispatches.
